// File: rtl/ecg_mem_pkg.sv
// Shared feature-memory geometry and flat-address decode helpers.
package ecg_mem_pkg;

  localparam int NUM_BANKS  = 8;
  localparam int BANK_AW    = 10;
  localparam int BANK_SEL_W = $clog2(NUM_BANKS);
  localparam int ADDR_WIDTH = BANK_SEL_W + BANK_AW;
  localparam int DATA_WIDTH = 8;

  // Upper address bits select the bank.
  function automatic logic [BANK_SEL_W-1:0] bank_of(input logic [ADDR_WIDTH-1:0] addr);
    return addr[ADDR_WIDTH-1:BANK_AW];
  endfunction

  // Lower address bits are the word offset inside the bank.
  function automatic logic [BANK_AW-1:0] offset_of(input logic [ADDR_WIDTH-1:0] addr);
    return addr[BANK_AW-1:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; pointer moves just past the winner whenever a grant is issued.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] idx;
  logic             found;

  // Search from the pointer, wrapping naturally since NUM_REQ is a power of 2.
  always_comb begin
    gnt    = '0;
    winner = ptr;
    idx    = ptr;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + PTR_W'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    if (en && found) gnt[winner] = 1'b1;
  end

  // Pointer advances only on an actual grant; frozen while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else if (en && found) ptr <= winner + PTR_W'(1);
  end

endmodule

// File: rtl/feature_bank_arbiter.sv
// Shares the feature memory banks between NUM_RD readers and one writer:
// address decode, per-bank round-robin read arbitration, registered bank
// drive, and a fixed two-cycle tagged return path for read data.
module feature_bank_arbiter
  import ecg_mem_pkg::*;
#(
  parameter int NUM_RD = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            spi_start,
  input  logic [NUM_RD-1:0]               rd_req,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]    rd_addr,
  output logic [NUM_RD-1:0]               rd_gnt,
  output logic [NUM_RD-1:0]               rd_vld,
  output logic [NUM_RD*DATA_WIDTH-1:0]    rd_data,
  input  logic                            wr_req,
  input  logic [ADDR_WIDTH-1:0]           wr_addr,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  output logic                            wr_gnt,
  output logic [NUM_BANKS-1:0]            bank_csen,
  output logic [NUM_BANKS-1:0]            bank_rdena,
  output logic [NUM_BANKS*ADDR_WIDTH-1:0] bank_raddr,
  output logic [NUM_BANKS-1:0]            bank_wrenb,
  output logic [ADDR_WIDTH-1:0]           bank_waddr,
  output logic [DATA_WIDTH-1:0]           bank_wdata,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] bank_rdata
);

  logic                  grant_ok;
  logic [BANK_SEL_W-1:0] rd_bank  [NUM_RD];
  logic [BANK_AW-1:0]    rd_off   [NUM_RD];
  logic [NUM_RD-1:0]     bank_req [NUM_BANKS];
  logic [NUM_RD-1:0]     bank_gnt [NUM_BANKS];
  logic [BANK_AW-1:0]    bank_off [NUM_BANKS];

  logic [NUM_RD-1:0]     vld_p1;
  logic [NUM_RD-1:0]     vld_p2;
  logic [BANK_SEL_W-1:0] bank_p1  [NUM_RD];
  logic [BANK_SEL_W-1:0] bank_p2  [NUM_RD];

  // Grants are held off during preload and while reset is asserted.
  assign grant_ok = rst_n & ~spi_start;
  assign wr_gnt   = wr_req & grant_ok;

  // Decode each reader's flat address and build the per-bank request sets.
  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      rd_bank[r] = bank_of(rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH]);
      rd_off[r]  = offset_of(rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH]);
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int r = 0; r < NUM_RD; r++) begin
        bank_req[b][r] = rd_req[r] && (rd_bank[r] == BANK_SEL_W'(b));
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_arb
    rr_arbiter #(.NUM_REQ(NUM_RD)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (grant_ok),
      .req   (bank_req[b]),
      .gnt   (bank_gnt[b])
    );
  end

  // Merge per-bank grants per reader and select each bank's winning offset.
  always_comb begin
    rd_gnt = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      rd_gnt      = rd_gnt | bank_gnt[b];
      bank_off[b] = '0;
      for (int r = 0; r < NUM_RD; r++) begin
        if (bank_gnt[b][r]) bank_off[b] = bank_off[b] | rd_off[r];
      end
    end
  end

  // ---- stage p1: bank drive registers ----
  // Register bank controls for this cycle's grants; idle banks drop back to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_rdena <= '0;
      bank_raddr <= '0;
      bank_wrenb <= '0;
      bank_waddr <= '0;
      bank_wdata <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_rdena[b]                          <= |bank_gnt[b];
        bank_raddr[b*ADDR_WIDTH +: ADDR_WIDTH] <= ADDR_WIDTH'(bank_off[b]);
      end
      bank_wrenb <= wr_gnt ? (NUM_BANKS'(1) << bank_of(wr_addr)) : '0;
      bank_waddr <= wr_gnt ? ADDR_WIDTH'(offset_of(wr_addr)) : '0;
      bank_wdata <= wr_gnt ? wr_data : '0;
    end
  end

  assign bank_csen = bank_rdena | bank_wrenb;

  // Tag pipeline: carries {valid, bank} alongside the memory access so the
  // returning data can be picked from the right bank two cycles after grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= '0;
      vld_p2 <= '0;
      for (int r = 0; r < NUM_RD; r++) begin
        bank_p1[r] <= '0;
        bank_p2[r] <= '0;
      end
    end else begin
      vld_p1 <= rd_gnt;
      vld_p2 <= vld_p1;
      for (int r = 0; r < NUM_RD; r++) begin
        bank_p1[r] <= rd_bank[r];
        bank_p2[r] <= bank_p1[r];
      end
    end
  end

  // ---- stage p2: return mux ----
  // Route the tagged bank's registered data to each reader; zero when idle.
  always_comb begin
    rd_vld  = vld_p2;
    rd_data = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      if (vld_p2[r]) rd_data[r*DATA_WIDTH +: DATA_WIDTH] = bank_rdata[bank_p2[r]*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_feature_bank_arbiter.sv
// Directed bench for feature_bank_arbiter with a read-first bank memory model.
module tb_feature_bank_arbiter;

  localparam int NB = 8;
  localparam int NR = 4;
  localparam int AW = 13;
  localparam int DW = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           spi_start;
  logic [NR-1:0]  rd_req;
  logic [NR*AW-1:0] rd_addr;
  logic [NR-1:0]  rd_gnt;
  logic [NR-1:0]  rd_vld;
  logic [NR*DW-1:0] rd_data;
  logic           wr_req;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic           wr_gnt;
  logic [NB-1:0]  bank_csen;
  logic [NB-1:0]  bank_rdena;
  logic [NB*AW-1:0] bank_raddr;
  logic [NB-1:0]  bank_wrenb;
  logic [AW-1:0]  bank_waddr;
  logic [DW-1:0]  bank_wdata;
  logic [NB*DW-1:0] bank_rdata = '0;

  logic [7:0] mem [NB][1024];
  logic       mem_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  feature_bank_arbiter #(.NUM_RD(NR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_start  (spi_start),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_gnt     (rd_gnt),
    .rd_vld     (rd_vld),
    .rd_data    (rd_data),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_gnt     (wr_gnt),
    .bank_csen  (bank_csen),
    .bank_rdena (bank_rdena),
    .bank_raddr (bank_raddr),
    .bank_wrenb (bank_wrenb),
    .bank_waddr (bank_waddr),
    .bank_wdata (bank_wdata),
    .bank_rdata (bank_rdata)
  );

  always #5 clk = ~clk;

  // Initial contents: byte = {bank,5'b0} ^ offset ^ 0xA0; bank 5 word 0 preset to 0x11.
  function automatic logic [7:0] pat(input int b, input int o);
    return 8'((b << 5) ^ o ^ 8'hA0);
  endfunction

  // Bank memories: 1-cycle registered read, read-before-write on the same word.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int b = 0; b < NB; b++)
        for (int o = 0; o < 1024; o++)
          mem[b][o] <= pat(b, o);
      mem[5][0] <= 8'h11;
      mem_ready <= 1'b1;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (bank_rdena[b]) bank_rdata[b*DW +: DW] <= mem[b][bank_raddr[b*AW +: 10]];
        if (bank_wrenb[b]) mem[b][bank_waddr[9:0]] <= bank_wdata;
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset with every request high
    rst_n = 1'b0; spi_start = 1'b0;
    rd_req = 4'hF; rd_addr = '0;
    wr_req = 1'b1; wr_addr = '0; wr_data = 8'hA0;
    repeat (3) cyc();
    chk("rst_rd_gnt", rd_gnt, 0);
    chk("rst_wr_gnt", wr_gnt, 0);
    chk("rst_rd_vld", rd_vld, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_csen", bank_csen, 0);
    chk("rst_wrenb", bank_wrenb, 0);
    chk("rst_raddr", bank_raddr, 0);
    chk("rst_wdata", bank_wdata, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_rd_gnt", rd_gnt, 4'b0001);
    chk("rel_wr_gnt", wr_gnt, 1);
    cyc();
    rd_req = '0; wr_req = 1'b0;
    #1;
    chk("rel_rdena", bank_rdena, 8'h01);
    chk("rel_wrenb", bank_wrenb, 8'h01);
    chk("rel_csen", bank_csen, 8'h01);
    cyc();
    chk("rel_rd_vld", rd_vld, 4'b0001);
    chk("rel_rd_data", rd_data, 32'h0000_00A0);
    cyc();

    // 2: single read, reader 2, bank 3 offset 5
    rd_req = 4'b0100; rd_addr[2*AW +: AW] = 13'h0C05;
    #1;
    chk("single_gnt", rd_gnt, 4'b0100);
    cyc();
    rd_req = '0;
    #1;
    chk("single_rdena", bank_rdena, 8'h08);
    chk("single_raddr", bank_raddr[3*AW +: AW], 13'd5);
    chk("single_csen", bank_csen, 8'h08);
    chk("single_vld_early", rd_vld, 0);
    cyc();
    chk("single_vld", rd_vld, 4'b0100);
    chk("single_data", rd_data, 32'h00C5_0000);
    cyc();
    chk("single_vld_drop", rd_vld, 0);

    // 3: all readers hold bank 1 -> grants rotate 0,1,2,3,0
    for (int r = 0; r < NR; r++) rd_addr[r*AW +: AW] = 13'(13'h0400 + r);
    for (int k = 0; k < 7; k++) begin
      rd_req = (k < 5) ? 4'hF : 4'h0;
      #1;
      chk($sformatf("conf_gnt%0d", k), rd_gnt, (k < 5) ? (4'b0001 << (k % 4)) : 4'b0000);
      chk($sformatf("conf_vld%0d", k), rd_vld, (k >= 2) ? (4'b0001 << ((k - 2) % 4)) : 4'b0000);
      if (k >= 2)
        chk($sformatf("conf_data%0d", k), rd_data[((k - 2) % 4)*DW +: DW], 8'h80 ^ 8'((k - 2) % 4));
      cyc();
    end

    // 4: four readers on banks 0,2,5,7 in parallel
    rd_addr = {13'h1C3F, 13'h1432, 13'h0821, 13'h0010};
    rd_req = 4'hF;
    #1;
    chk("par_gnt", rd_gnt, 4'hF);
    cyc();
    rd_req = '0;
    #1;
    chk("par_rdena", bank_rdena, 8'hA5);
    chk("par_raddr7", bank_raddr[7*AW +: AW], 13'h03F);
    cyc();
    chk("par_vld", rd_vld, 4'hF);
    chk("par_data", rd_data, 32'h7F32_C1B0);
    cyc();

    // 5: same-address read and write in one cycle returns old data
    rd_addr[0 +: AW] = 13'h1400; rd_req = 4'b0001;
    wr_addr = 13'h1400; wr_data = 8'h7F; wr_req = 1'b1;
    #1;
    chk("rw_rd_gnt", rd_gnt, 4'b0001);
    chk("rw_wr_gnt", wr_gnt, 1);
    cyc();
    rd_req = '0; wr_req = 1'b0;
    #1;
    chk("rw_wrenb", bank_wrenb, 8'h20);
    chk("rw_rdena", bank_rdena, 8'h20);
    chk("rw_csen", bank_csen, 8'h20);
    chk("rw_waddr", bank_waddr, 0);
    chk("rw_wdata", bank_wdata, 8'h7F);
    cyc();
    rd_req = 4'b0001;
    #1;
    chk("rw_old_vld", rd_vld, 4'b0001);
    chk("rw_old_data", rd_data, 32'h0000_0011);
    chk("rw_reread_gnt", rd_gnt, 4'b0001);
    cyc();
    rd_req = '0;
    cyc();
    chk("rw_new_data", rd_data, 32'h0000_007F);
    cyc();

    // 6: spi_start freeze, then reset mid-read
    rd_addr[1*AW +: AW] = 13'h1809; rd_addr[3*AW +: AW] = 13'h180A;
    rd_req = 4'b1010;
    #1;
    chk("spi_pre_gnt", rd_gnt, 4'b0010);
    cyc();
    spi_start = 1'b1; rd_req = 4'b1000;
    wr_addr = 13'h1000; wr_data = 8'h55; wr_req = 1'b1;
    #1;
    chk("spi1_gnt", rd_gnt, 0);
    chk("spi1_wr_gnt", wr_gnt, 0);
    chk("spi1_rdena", bank_rdena, 8'h40);
    cyc();
    #1;
    chk("spi2_gnt", rd_gnt, 0);
    chk("spi2_vld", rd_vld, 4'b0010);
    chk("spi2_data", rd_data, 32'h0000_6900);
    chk("spi2_wrenb", bank_wrenb, 0);
    cyc();
    chk("spi3_gnt", rd_gnt, 0);
    chk("spi3_csen", bank_csen, 0);
    cyc();
    spi_start = 1'b0; wr_req = 1'b0; rd_req = 4'b1010;
    #1;
    chk("spi_ptr_kept", rd_gnt, 4'b1000);
    cyc();
    rd_req = '0; rst_n = 1'b0;
    #1;
    chk("midrst_csen", bank_csen, 0);
    chk("midrst_vld0", rd_vld, 0);
    cyc();
    chk("midrst_vld1", rd_vld, 0);
    chk("midrst_data1", rd_data, 0);
    rst_n = 1'b1;
    cyc();
    chk("midrst_vld2", rd_vld, 0);
    cyc();
    chk("midrst_vld3", rd_vld, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
